// File: rtl/life_pkg.sv
// life_pkg: shared state encoding, row type and bank/row address packing for the
// life engine pass sequencer.
package life_pkg;

  localparam int DEF_DBITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  typedef logic [DEF_DBITS-2:0] row_t;

  // Bank bit lands on address bit dbits-1; the caller truncates to its own width.
  function automatic logic [15:0] pack_addr(input logic bank, input logic [14:0] row,
                                            input int dbits);
    return {1'b0, row} | (16'(bank) << (dbits - 1));
  endfunction

endpackage

// File: rtl/life_wr_pipe.sv
// life_wr_pipe: WR_LAT-deep {valid, row} delay line that turns read issues into
// engine writes, so writes follow issues rather than wall-clock time.
module life_wr_pipe #(
  parameter int WR_LAT = 4,
  parameter int RW     = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  output logic          we,
  output logic [RW-1:0] wr_row,
  output logic          pending
);

  logic [WR_LAT-1:0] vld_q;
  logic [RW-1:0]     row_q [WR_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < WR_LAT; i++) row_q[i] <= '0;
    end else begin
      vld_q    <= WR_LAT'({vld_q, in_valid});
      row_q[0] <= in_row;
      for (int i = 1; i < WR_LAT; i++) row_q[i] <= row_q[i-1];
    end
  end

  // Writes still travelling toward the output stage (the output stage excluded).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < WR_LAT - 1; i++) pending = pending | vld_q[i];
  end

  assign we     = vld_q[WR_LAT-1];
  assign wr_row = row_q[WR_LAT-1];

endmodule

// File: rtl/life_pass_ctrl.sv
// life_pass_ctrl: generation-pass sequencer, video read arbiter and init loader for
// the linear life engine. Optional LIFE_CTRL_SINGLE_STEP_EN adds a per-row step input.
module life_pass_ctrl
  import life_pkg::*;
#(
  parameter int DBITS  = DEF_DBITS,
  parameter int GENS   = 1,
  parameter int WR_LAT = 4,
  parameter int RD_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LIFE_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             start,
  input  logic [15:0]      npass,
  input  logic             stop,
  input  logic             load,
  input  logic             init_valid,
  output logic             init_ready,
  input  logic             vid_req,
  input  logic [DBITS-2:0] vid_row,
  output logic             vid_gnt,
  output logic             vid_valid,
  output logic [DBITS-1:0] raddr,
  output logic [DBITS-1:0] waddr,
  output logic             we,
  output logic             sh,
  output logic             ld,
  output logic             init,
  output logic             busy,
  output logic             pass_done,
  output logic [15:0]      gen_count,
  output logic             disp_bank
);

  localparam int RW     = DBITS - 1;
  localparam int ROWS   = 2 ** RW;
  localparam int ISSUES = ROWS + 2 * GENS;
  localparam int KW     = $clog2(ISSUES + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_INIT  = INIT;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic              src_bank;
  logic [KW-1:0]     k;
  logic [RW-1:0]     init_row;
  logic              stop_lat;
  logic [15:0]       pass_target;
  logic [15:0]       pass_cnt;
  logic [15:0]       pass_next;
  logic [RD_LAT-1:0] vid_pipe;

  logic              step_ok;
  logic              issue;
  logic              init_beat;
  logic              more_passes;
  logic [RW-1:0]     rd_row;
  logic [RW-1:0]     wr_row_in;
  logic              wr_in_valid;
  logic              pipe_we;
  logic [RW-1:0]     pipe_row;
  logic              pipe_pending;

`ifdef LIFE_CTRL_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Video always wins; gating with reset keeps every output low while reset is held.
  assign vid_gnt   = vid_req && reset && (state != ST_INIT);
  assign ld        = vid_gnt;
  assign issue     = (state == ST_RUN) && !vid_gnt && step_ok;
  assign sh        = issue;
  assign init_ready = (state == ST_INIT);
  assign init      = init_ready;
  assign init_beat = init_ready && init_valid;
  assign busy      = (state != ST_IDLE);

  // Reads start GENS rows before row 0 and wrap, giving the engine its overlap rows.
  assign rd_row      = RW'(int'(k) - GENS);
  assign wr_row_in   = RW'(int'(k) - 2 * GENS);
  assign wr_in_valid = issue && (k >= KW'(2 * GENS));

  assign raddr = vid_gnt ? DBITS'(pack_addr(disp_bank, 15'(vid_row), DBITS)) :
                 issue   ? DBITS'(pack_addr(src_bank, 15'(rd_row), DBITS))  : '0;

  assign we    = init_beat || pipe_we;
  assign waddr = init_beat ? DBITS'(pack_addr(1'b0, 15'(init_row), DBITS))      :
                 pipe_we   ? DBITS'(pack_addr(~src_bank, 15'(pipe_row), DBITS)) : '0;

  assign pass_done   = (state == ST_DRAIN) && !pipe_pending;
  assign pass_next   = pass_cnt + 16'd1;
  assign more_passes = ((pass_target == 16'd0) || (pass_next != pass_target)) &&
                       !stop_lat && !stop;

  life_wr_pipe #(
    .WR_LAT (WR_LAT),
    .RW     (RW)
  ) u_wr_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (wr_in_valid),
    .in_row   (wr_row_in),
    .we       (pipe_we),
    .wr_row   (pipe_row),
    .pending  (pipe_pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_pipe <= '0;
    end else begin
      vid_pipe <= RD_LAT'({vid_pipe, vid_gnt});
    end
  end

  assign vid_valid = vid_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      src_bank    <= 1'b0;
      disp_bank   <= 1'b0;
      k           <= '0;
      init_row    <= '0;
      stop_lat    <= 1'b0;
      pass_target <= '0;
      pass_cnt    <= '0;
      gen_count   <= '0;
    end else begin
      if (stop && (state == ST_RUN || state == ST_DRAIN)) stop_lat <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            k           <= '0;
            pass_cnt    <= '0;
            pass_target <= npass;
            stop_lat    <= 1'b0;
          end else if (load) begin
            state    <= ST_INIT;
            init_row <= '0;
          end
        end
        ST_INIT: begin
          if (init_beat) begin
            init_row <= init_row + 1'b1;
            if (init_row == RW'(ROWS - 1)) begin
              state     <= ST_IDLE;
              src_bank  <= 1'b0;
              disp_bank <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            k <= k + 1'b1;
            if (k == KW'(ISSUES - 1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The final write of the pass is on the engine bus this cycle.
          if (pass_done) begin
            gen_count <= gen_count + 1'b1;
            pass_cnt  <= pass_next;
            disp_bank <= ~src_bank;
            src_bank  <= ~src_bank;
            k         <= '0;
            stop_lat  <= 1'b0;
            state     <= more_passes ? ST_RUN : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_pass_ctrl.sv
// tb_life_pass_ctrl: checks life_pass_ctrl (DBITS=4, GENS=1) against a timestamped
// event model, an IDLE vector table, directed corner sequences and random traffic.
module tb_life_pass_ctrl;

  localparam int DBITS  = 4;
  localparam int GENS   = 1;
  localparam int WR_LAT = 4;
  localparam int RD_LAT = 3;
  localparam int ROWS   = 8;
  localparam int ISSUES = ROWS + 2 * GENS;

  localparam int M_IDLE  = 0;
  localparam int M_INIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, load, init_valid, vid_req;
  logic [15:0] npass;
  logic [2:0]  vid_row;
  logic        init_ready, vid_gnt, vid_valid, we, sh, ld, init, busy, pass_done, disp_bank;
  logic [3:0]  raddr, waddr;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  life_pass_ctrl #(
    .DBITS  (DBITS),
    .GENS   (GENS),
    .WR_LAT (WR_LAT),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .npass      (npass),
    .stop       (stop),
    .load       (load),
    .init_valid (init_valid),
    .init_ready (init_ready),
    .vid_req    (vid_req),
    .vid_row    (vid_row),
    .vid_gnt    (vid_gnt),
    .vid_valid  (vid_valid),
    .raddr      (raddr),
    .waddr      (waddr),
    .we         (we),
    .sh         (sh),
    .ld         (ld),
    .init       (init),
    .busy       (busy),
    .pass_done  (pass_done),
    .gen_count  (gen_count),
    .disp_bank  (disp_bank)
  );

  // Reference model: mode plus timestamped queues of future writes and video strobes.
  int          m_mode, m_k, m_init_row, m_target, m_done, now;
  logic [15:0] m_gen;
  bit          m_src, m_disp, m_stop;
  int          wr_time[$];
  logic [2:0]  wr_row[$];
  int          vv_time[$];

  logic        e_gnt, e_sh, e_beat, e_due, e_vv, e_done;
  logic [3:0]  e_raddr, e_waddr;
  logic [33:0] exp_vec, act_vec;

  int vectors = 0;
  int miscompares = 0;
  int obs_we, obs_done;

  typedef struct {
    logic       vreq;
    logic [2:0] vrow;
    logic       stp;
    logic       e_gnt;
    logic [3:0] e_raddr;
    logic       e_busy;
  } idle_vec_t;

  idle_vec_t tbl [6];

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0; m_init_row = 0; m_target = 0; m_done = 0;
    m_gen = '0; m_src = 0; m_disp = 0; m_stop = 0;
    wr_time.delete(); wr_row.delete(); vv_time.delete();
  endtask

  task automatic model_expect();
    logic [2:0] rr;
    rr      = 3'((m_k + ROWS - GENS) % ROWS);
    e_gnt   = vid_req && reset && (m_mode != M_INIT);
    e_sh    = (m_mode == M_RUN) && !e_gnt;
    e_beat  = (m_mode == M_INIT) && init_valid;
    e_due   = (wr_time.size() > 0) && (wr_time[0] == now);
    e_vv    = (vv_time.size() > 0) && (vv_time[0] == now);
    e_done  = e_due && (wr_row[0] == 3'(ROWS - 1));
    e_raddr = e_gnt ? {m_disp, vid_row} : (e_sh ? {m_src, rr} : 4'h0);
    e_waddr = e_beat ? {1'b0, 3'(m_init_row)} : (e_due ? {~m_src, wr_row[0]} : 4'h0);
    exp_vec = {m_mode == M_INIT, e_gnt, e_vv, e_raddr, e_waddr, e_beat || e_due, e_sh,
               e_gnt, m_mode == M_INIT, m_mode != M_IDLE, e_done, m_gen, m_disp};
  endtask

  task automatic model_advance();
    if (!reset) begin
      model_reset();
    end else begin
      if (e_vv) void'(vv_time.pop_front());
      if (e_gnt) vv_time.push_back(now + RD_LAT);
      if (e_due) begin
        void'(wr_time.pop_front());
        void'(wr_row.pop_front());
      end
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            m_mode = M_RUN; m_k = 0; m_done = 0; m_target = int'(npass); m_stop = 0;
          end else if (load) begin
            m_mode = M_INIT; m_init_row = 0;
          end
        end
        M_INIT: begin
          if (e_beat) begin
            if (m_init_row == ROWS - 1) begin
              m_mode = M_IDLE; m_src = 0; m_disp = 0;
            end else m_init_row++;
          end
        end
        M_RUN: begin
          if (stop) m_stop = 1;
          if (e_sh) begin
            if (m_k >= 2 * GENS) begin
              wr_time.push_back(now + WR_LAT);
              wr_row.push_back(3'(m_k - 2 * GENS));
            end
            m_k++;
            if (m_k == ISSUES) m_mode = M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (stop) m_stop = 1;
          if (e_done) begin
            m_gen++; m_done++;
            m_disp = ~m_src; m_src = ~m_src;
            if ((m_target == 0 || m_done != m_target) && !m_stop) begin
              m_mode = M_RUN; m_k = 0;
            end else m_mode = M_IDLE;
            m_stop = 0;
          end
        end
        default: ;
      endcase
    end
    now++;
  endtask

  function automatic logic [33:0] outputs_now();
    return {init_ready, vid_gnt, vid_valid, raddr, waddr, we, sh, ld, init, busy,
            pass_done, gen_count, disp_bank};
  endfunction

  task automatic sample_cycle();
    @(negedge clk);
    model_expect();
    act_vec = outputs_now();
    checkOutput($sformatf("cycle%0d", now), act_vec, exp_vec);
    if (we) obs_we++;
    if (pass_done) obs_done++;
  endtask

  task automatic advance_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    sample_cycle();
    advance_cycle();
  endtask

  task automatic run_until_idle(input int budget);
    for (int c = 0; c < budget && m_mode != M_IDLE; c++) applyStimulus();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 3'd3, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 1'b0, 1'b1, 4'h3, 1'b0};
    tbl[2] = '{1'b1, 3'd7, 1'b1, 1'b1, 4'h7, 1'b0};
    tbl[3] = '{1'b0, 3'd5, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[4] = '{1'b1, 3'd0, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b0};

    reset = 1'b0; start = 0; stop = 0; load = 0; init_valid = 0; vid_req = 0;
    vid_row = '0; npass = '0; now = 0; obs_we = 0; obs_done = 0;
    model_reset();
    #1;
    checkOutput("reset_outputs", outputs_now(), 34'h0);
    vid_req = 1'b1;
    applyStimulus();
    vid_req = 1'b0;
    applyStimulus();
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      vid_req = tbl[i].vreq; vid_row = tbl[i].vrow; stop = tbl[i].stp;
      sample_cycle();
      checkOutput($sformatf("idle_vec%0d", i), 34'({vid_gnt, ld, raddr, busy}),
                  34'({tbl[i].e_gnt, tbl[i].e_gnt, tbl[i].e_raddr, tbl[i].e_busy}));
      advance_cycle();
    end
    vid_req = 0; stop = 0;
    for (int i = 0; i < RD_LAT; i++) applyStimulus();

    // Initial image load with one idle gap in the beat stream.
    load = 1; applyStimulus(); load = 0;
    obs_we = 0;
    for (int i = 0; i < 9; i++) begin
      init_valid = (i != 3);
      applyStimulus();
    end
    init_valid = 0;
    applyStimulus();
    checkOutput("init_writes", 34'(obs_we), 34'd8);
    checkOutput("init_end", 34'({busy, disp_bank}), 34'b00);

    // Single wrapped pass.
    obs_we = 0; obs_done = 0;
    npass = 16'd1; start = 1; applyStimulus(); start = 0;
    run_until_idle(100);
    checkOutput("wrap_writes", 34'(obs_we), 34'd8);
    checkOutput("wrap_done", 34'(obs_done), 34'd1);
    checkOutput("wrap_state", 34'({busy, gen_count, disp_bank}), 34'({1'b0, 16'd1, 1'b1}));

    // Video stall mid-pass.
    start = 1; applyStimulus(); start = 0;
    for (int i = 0; i < 3; i++) applyStimulus();
    vid_req = 1;
    for (int i = 0; i < 3; i++) begin
      vid_row = 3'(2 * i + 1);
      applyStimulus();
    end
    vid_req = 0;
    run_until_idle(100);
    checkOutput("stall_state", 34'({busy, gen_count, disp_bank}), 34'({1'b0, 16'd2, 1'b0}));

    // Free-running passes with stop during the second pass.
    reset = 0; #1; model_reset(); applyStimulus(); reset = 1;
    npass = 16'd0; start = 1; applyStimulus(); start = 0;
    for (int c = 0; c < 200 && !(m_done == 1 && m_mode == M_RUN && m_k == 4); c++) applyStimulus();
    stop = 1; applyStimulus(); stop = 0;
    run_until_idle(200);
    checkOutput("stop_state", 34'({busy, gen_count, disp_bank}), 34'({1'b0, 16'd2, 1'b0}));
    npass = 16'd1; start = 1; applyStimulus(); start = 0;
    sample_cycle();
    checkOutput("stop_next_bank", 34'(raddr), 34'h7);
    advance_cycle();
    run_until_idle(100);

    // Reset at issue 5 of a pass, then restart from bank 0.
    start = 1; applyStimulus(); start = 0;
    for (int c = 0; c < 50 && !(m_mode == M_RUN && m_k == 5); c++) applyStimulus();
    reset = 0;
    #1;
    checkOutput("reset_mid_run", outputs_now(), 34'h0);
    model_reset();
    for (int i = 0; i < 2; i++) applyStimulus();
    reset = 1;
    for (int i = 0; i < WR_LAT + 1; i++) applyStimulus();
    start = 1; applyStimulus(); start = 0;
    sample_cycle();
    checkOutput("restart_raddr", 34'(raddr), 34'h7);
    advance_cycle();
    run_until_idle(100);

    // start and load together: RUN wins.
    start = 1; load = 1; applyStimulus(); start = 0; load = 0;
    sample_cycle();
    checkOutput("start_over_load", 34'({init_ready, busy}), 34'b01);
    advance_cycle();
    run_until_idle(100);

    // Random traffic against the model.
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        load = 1; applyStimulus(); load = 0;
        for (int c = 0; c < 200 && m_mode != M_IDLE; c++) begin
          init_valid = 1'($urandom_range(0, 1));
          vid_req = ($urandom_range(0, 3) == 0);
          vid_row = 3'($urandom);
          applyStimulus();
        end
      end else begin
        npass = 16'($urandom_range(0, 3));
        start = 1; applyStimulus(); start = 0;
        for (int c = 0; c < 400 && m_mode != M_IDLE; c++) begin
          vid_req = ($urandom_range(0, 3) == 0);
          vid_row = 3'($urandom);
          stop = (npass == 16'd0) ? ((c > 100) || ($urandom_range(0, 30) == 0))
                                  : ($urandom_range(0, 60) == 0);
          applyStimulus();
        end
      end
      init_valid = 0; vid_req = 0; stop = 0;
      for (int i = 0; i < RD_LAT; i++) applyStimulus();
      checkOutput($sformatf("rand_idle%0d", r), 34'(busy), 34'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
